vnu_layer_update: RTL and testbench

- Variable-node side of the layered offset min-sum LDPC decoder. It is the counterpart of the check-node min-sum unit.
- For one layer (one check row of DEG columns), it does three things:
  - accepts APP LLRs and the previous check-to-variable (C2V) messages serially;
  - forms variable-to-check (V2C) messages and presents them in parallel to the check-node unit;
  - takes the new C2V messages back and streams out the updated APP LLRs plus hard decisions.
- It sits between the APP LLR memory and the check-node unit.

---
 rtl/vnu_layer_update.sv | 189 ++++++++++++++++++
 tb/tb_vnu_layer_update.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vnu_layer_update.sv
`default_nettype none
// ============================================================================
// Module   : vnu_layer_update
// Purpose  : Variable-node update for a layered offset min-sum LDPC decoder.
//            Serially loads APP LLRs and old C2V messages for one check row,
//            presents the V2C messages in parallel to the check-node unit,
//            then streams out updated APP LLRs and hard decisions once the
//            new C2V messages return.
// Ports    : clk, rst_n (async, active low)
//            start                          - begin a layer (IDLE only)
//            app_in_valid/app_in_ready      - serial load handshake
//            app_in, c2v_old                - APP LLR and old C2V of column k
//            v2c_out, v2c_valid             - parallel V2C bus to the CNU
//            c2v_valid, c2v_in              - parallel new C2V bus from the CNU
//            app_out_valid/app_out_ready    - serial output handshake
//            app_out, app_out_idx, hard_bit - updated APP beat
//            busy, layer_done               - status
// Revision : 1.0 - initial release
// ============================================================================
module vnu_layer_update #(
   parameter int W     = 5,
   parameter int APP_W = 8,
   parameter int DEG   = 20,
   parameter int IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 app_in_valid,
   output logic                 app_in_ready,
   input  logic [APP_W-1:0]     app_in,
   input  logic [W-1:0]         c2v_old,
   output logic [DEG*W-1:0]     v2c_out,
   output logic                 v2c_valid,
   input  logic                 c2v_valid,
   input  logic [DEG*W-1:0]     c2v_in,
   output logic                 app_out_valid,
   input  logic                 app_out_ready,
   output logic [APP_W-1:0]     app_out,
   output logic [IDX_W-1:0]     app_out_idx,
   output logic                 hard_bit,
   output logic                 busy,
   output logic                 layer_done
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_LOAD  = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_WRITE = 2'd3;

   localparam logic signed [APP_W:0]   c_APP_MAX = (APP_W+1)'((1 << (APP_W-1)) - 1);
   localparam logic signed [APP_W:0]   c_APP_MIN = -c_APP_MAX;
   localparam logic signed [APP_W-1:0] c_V2C_MAX = APP_W'((1 << (W-1)) - 1);
   localparam logic signed [APP_W-1:0] c_V2C_MIN = -c_V2C_MAX;
   localparam logic [IDX_W-1:0]        c_LAST    = IDX_W'(DEG-1);

   // Symmetric clamps: the most negative code is never produced because the
   // check-node sign-magnitude conversion cannot represent it.
   function automatic logic [APP_W-1:0] sat_app(input logic signed [APP_W:0] x);
      if (x > c_APP_MAX)      return c_APP_MAX[APP_W-1:0];
      else if (x < c_APP_MIN) return c_APP_MIN[APP_W-1:0];
      else                    return x[APP_W-1:0];
   endfunction

   function automatic logic [W-1:0] sat_v2c(input logic signed [APP_W-1:0] x);
      if (x > c_V2C_MAX)      return c_V2C_MAX[W-1:0];
      else if (x < c_V2C_MIN) return c_V2C_MIN[W-1:0];
      else                    return x[W-1:0];
   endfunction

   logic [1:0]        r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_cnt;
   logic [DEG*W-1:0]  r_v2c;
   logic [APP_W-1:0]  r_app_out;
   logic [IDX_W-1:0]  r_app_idx;
   logic              r_layer_done;
   logic [APP_W-1:0]  r_diff [DEG];
   logic [W-1:0]      r_c2v  [DEG];

   logic              w_in_acc, w_out_acc, w_c2v_take, w_last;
   logic signed [APP_W:0] w_diff_full, w_sum;
   logic [APP_W-1:0]  w_diff, w_rd_diff, w_app_nxt;
   logic [W-1:0]      w_v2c, w_rd_c2v;
   logic [IDX_W-1:0]  w_rd_idx;

   assign w_in_acc   = (r_state == c_LOAD)  && app_in_valid;
   assign w_out_acc  = (r_state == c_WRITE) && app_out_ready;
   assign w_c2v_take = (r_state == c_WAIT)  && c2v_valid;
   assign w_last     = (r_cnt == c_LAST);

   // Load path: diff = sat(app - c2v_old) in one extra bit of headroom.
   assign w_diff_full = {app_in[APP_W-1], app_in}
                      - {{(APP_W+1-W){c2v_old[W-1]}}, c2v_old};
   assign w_diff      = sat_app(w_diff_full);
   assign w_v2c       = sat_v2c(w_diff);

   // Output path computes the beat that will be presented after the next
   // edge: column 0 straight off the CNU bus when leaving WAIT, otherwise
   // the column following the one currently shown.
   assign w_rd_idx  = (r_state == c_WAIT || w_last) ? '0 : r_cnt + 1'b1;
   assign w_rd_diff = r_diff[w_rd_idx];
   assign w_rd_c2v  = (r_state == c_WAIT) ? c2v_in[0 +: W] : r_c2v[w_rd_idx];
   assign w_sum     = {w_rd_diff[APP_W-1], w_rd_diff}
                    + {{(APP_W+1-W){w_rd_c2v[W-1]}}, w_rd_c2v};
   assign w_app_nxt = sat_app(w_sum);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic. A start coinciding with the layer_done pulse belongs
   // to the finished layer's cycle and is dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (start && !r_layer_done) w_state_nxt = c_LOAD;
         c_LOAD:  if (w_in_acc && w_last)     w_state_nxt = c_WAIT;
         c_WAIT:  if (c2v_valid)              w_state_nxt = c_WRITE;
         c_WRITE: if (w_out_acc && w_last)    w_state_nxt = c_IDLE;
         default:                             w_state_nxt = c_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      app_in_ready  = 1'b0;
      v2c_valid     = 1'b0;
      app_out_valid = 1'b0;
      busy          = (r_state != c_IDLE);
      case (r_state)
         c_LOAD:  app_in_ready  = 1'b1;
         c_WAIT:  v2c_valid     = 1'b1;
         c_WRITE: app_out_valid = 1'b1;
         default: ;
      endcase
   end

   assign v2c_out     = r_v2c;
   assign app_out     = r_app_out;
   assign app_out_idx = r_app_idx;
   assign hard_bit    = r_app_out[APP_W-1];
   assign layer_done  = r_layer_done;

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_v2c        <= '0;
         r_app_out    <= '0;
         r_app_idx    <= '0;
         r_layer_done <= 1'b0;
      end else begin
         r_layer_done <= w_out_acc && w_last;
         if (r_state == c_IDLE && start) begin
            r_cnt <= '0;
         end
         if (w_in_acc) begin
            r_v2c[r_cnt*W +: W] <= w_v2c;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
         if (w_c2v_take) begin
            r_cnt     <= '0;
            r_app_out <= w_app_nxt;
            r_app_idx <= '0;
         end
         if (w_out_acc) begin
            r_cnt     <= w_rd_idx;
            r_app_out <= w_last ? '0 : w_app_nxt;
            r_app_idx <= w_rd_idx;
         end
      end
   end

   // Layer buffers; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (w_in_acc) begin
         r_diff[r_cnt] <= w_diff;
      end
      if (w_c2v_take) begin
         for (int i = 0; i < DEG; i++) begin
            r_c2v[i] <= c2v_in[i*W +: W];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vnu_layer_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_vnu_layer_update
// Purpose  : Self-checking bench for vnu_layer_update. Expected output beats
//            are queued when the new C2V bus is driven and popped as the DUT
//            presents accepted beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vnu_layer_update;
   localparam int W = 5, APP_W = 8, DEG = 20, IDX_W = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, app_in_valid, app_in_ready, v2c_valid, c2v_valid;
   logic app_out_valid, app_out_ready, hard_bit, busy, layer_done;
   logic [APP_W-1:0] app_in, app_out;
   logic [W-1:0]     c2v_old;
   logic [DEG*W-1:0] v2c_out, c2v_in;
   logic [IDX_W-1:0] app_out_idx;

   vnu_layer_update #(.W(W), .APP_W(APP_W), .DEG(DEG), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .app_in_valid(app_in_valid), .app_in_ready(app_in_ready),
      .app_in(app_in), .c2v_old(c2v_old),
      .v2c_out(v2c_out), .v2c_valid(v2c_valid),
      .c2v_valid(c2v_valid), .c2v_in(c2v_in),
      .app_out_valid(app_out_valid), .app_out_ready(app_out_ready),
      .app_out(app_out), .app_out_idx(app_out_idx), .hard_bit(hard_bit),
      .busy(busy), .layer_done(layer_done)
   );

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [APP_W-1:0] val;
      logic             hard;
   } beat_t;

   beat_t sb[$];
   int checks = 0;
   int errors = 0;
   int g_app[DEG], g_c2vo[DEG], g_c2vn[DEG];
   logic [DEG*W-1:0] obs_v2c;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_i(input int x, input int n);
      int m;
      m = (1 << (n-1)) - 1;
      if (x > m)  return m;
      if (x < -m) return -m;
      return x;
   endfunction

   task automatic check_all_zero(input string tag);
      chk(tag, {app_in_ready, v2c_valid, app_out_valid, busy, layer_done,
                app_out, app_out_idx, hard_bit, v2c_out}, '0);
   endtask

   task automatic fill(input int app, input int c2vo, input int c2vn);
      for (int i = 0; i < DEG; i++) begin
         g_app[i] = app; g_c2vo[i] = c2vo; g_c2vn[i] = c2vn;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEG; i++) begin
         g_app[i]  = int'($urandom_range(0, 255)) - 128;
         g_c2vo[i] = int'($urandom_range(0, 31)) - 16;
         g_c2vn[i] = int'($urandom_range(0, 31)) - 16;
      end
   endtask

   // One full layer. stall_beat holds ready low for 3 cycles on that beat;
   // abort_beat asserts reset while that beat is presented.
   task automatic run_layer(input bit gaps, input bit inject,
                            input int stall_beat, input int abort_beat);
      logic [DEG*W-1:0] exp_v2c;
      int    k, cyc, d, o, nstall;
      bit    v, rdy;
      beat_t b;

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);

      k = 0; cyc = 0;
      while (k < DEG && cyc < 400) begin
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         chk("in_ready_load", app_in_ready, 1);
         app_in_valid = v;
         app_in       = APP_W'(g_app[k]);
         c2v_old      = W'(g_c2vo[k]);
         start        = inject;
         c2v_valid    = inject;
         @(negedge clk);
         cyc++;
         if (v) k++;
      end
      app_in_valid = 1'b0; start = 1'b0; c2v_valid = 1'b0;
      chk("load_count", k, DEG);

      for (int i = 0; i < DEG; i++) begin
         d = sat_i(g_app[i] - g_c2vo[i], APP_W);
         exp_v2c[i*W +: W] = W'(sat_i(d, W));
         o = sat_i(d + g_c2vn[i], APP_W);
         b.idx  = IDX_W'(i);
         b.val  = APP_W'(o);
         b.hard = (o < 0);
         sb.push_back(b);
         c2v_in[i*W +: W] = W'(g_c2vn[i]);
      end
      chk("v2c_valid", v2c_valid, 1);
      chk("v2c_out", v2c_out, exp_v2c);
      obs_v2c = v2c_out;

      c2v_valid = 1'b1;
      @(negedge clk);
      c2v_valid = 1'b0;
      chk("v2c_valid_drop", v2c_valid, 0);
      chk("in_ready_write", app_in_ready, 0);
      app_in_valid = 1'b1;

      k = 0; cyc = 0; nstall = 0;
      while (k < DEG && cyc < 400) begin
         if (k == abort_beat) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("abort_outputs");
            sb.delete();
            app_in_valid = 1'b0; app_out_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         rdy = !(k == stall_beat && nstall < 3);
         if (app_out_valid && sb.size() > 0) begin
            b = sb[0];
            chk(rdy ? "out_val" : "hold_val", app_out, b.val);
            chk(rdy ? "out_idx" : "hold_idx", app_out_idx, b.idx);
            chk(rdy ? "out_hard" : "hold_hard", hard_bit, b.hard);
            if (rdy) begin
               void'(sb.pop_front());
               k++;
            end else begin
               nstall++;
            end
         end
         app_out_ready = rdy;
         @(negedge clk);
         cyc++;
      end
      app_out_ready = 1'b0; app_in_valid = 1'b0;
      chk("write_count", k, DEG);
      chk("layer_done", layer_done, 1);
      chk("busy_done", busy, 0);
      chk("app_out_valid_done", app_out_valid, 0);

      // start during the done pulse is dropped
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_single_pulse", layer_done, 0);
      chk("start_in_done_ignored", busy, 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; app_in_valid = 1'b0; app_in = '0;
      c2v_old = '0; c2v_valid = 1'b0; c2v_in = '0; app_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // Saturating V2C, positive outputs
      fill(20, 3, -4);
      run_layer(1'b0, 1'b0, -1, -1);
      chk("t2_v2c_col0", obs_v2c[0 +: W], 5'd15);

      // Reset in the middle of LOAD
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      app_in_valid = 1'b1; app_in = 8'd7; c2v_old = 5'd1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("midload_reset");
      @(negedge clk);
      rst_n = 1'b1; app_in_valid = 1'b0;
      @(negedge clk);
      chk("after_reset_idle", busy, 0);

      // Most negative APP input
      fill(-128, 5, -10);
      run_layer(1'b0, 1'b0, -1, -1);
      chk("t3_v2c_col19", obs_v2c[19*W +: W], 5'b10001);

      // Mixed columns
      fill_random();
      g_app[3] = -6; g_c2vo[3] = -2; g_c2vn[3] = 9;
      run_layer(1'b0, 1'b0, -1, -1);
      chk("t4_v2c_col3", obs_v2c[3*W +: W], 5'b11100);

      // Input gaps and output stall on beat 7
      fill_random();
      run_layer(1'b1, 1'b0, 7, -1);

      // Ignored start/c2v_valid during LOAD, reset at WRITE beat 10
      fill_random();
      run_layer(1'b0, 1'b1, -1, 10);
      chk("after_abort_idle", busy, 0);
      fill_random();
      run_layer(1'b0, 1'b0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
